// File: rtl/pulse_segment_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_segment_sequencer
//
// Steps the pulse-mode datapath (wrapped_delay_counter + output_multiplexer)
// through a list of timed segments. Segments are queued in a small FIFO over
// a valid/ready interface. After start, each segment is loaded into the
// counter and multiplexer, and the next one is loaded when the counter
// reports expiry.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   segment push handshake (cmd_ready = buffer not full)
//   cmd_shutter           shutter word for the segment
//   cmd_end_shutter       pulse-end shutter word for the segment
//   cmd_delay             segment duration in clk cycles
//   cmd_pulse_mode        pulse_mode for the segment
//   cmd_last              marks the final segment of a sequence
//   start, abort          single-cycle control pulses
//   dc_load, dc_l, dc_rst counter controls; dc_expired_pulse is its expiry
//   om_update, om_shutter, om_end_shutter, om_pulse_mode, om_enable
//                         multiplexer controls
//   busy                  sequence in progress
//   done                  one-cycle pulse at sequence end
//   underrun              sticky: a segment was needed but the buffer was empty
//   segment_count         segments loaded since the last start
// -----------------------------------------------------------------------------
module pulse_segment_sequencer #(
    parameter int DELAY_W   = 48,
    parameter int SHUTTER_W = 64,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [SHUTTER_W-1:0] cmd_shutter,
    input  logic [SHUTTER_W-1:0] cmd_end_shutter,
    input  logic [DELAY_W-1:0]   cmd_delay,
    input  logic                 cmd_pulse_mode,
    input  logic                 cmd_last,
    input  logic                 start,
    input  logic                 abort,
    output logic                 dc_load,
    output logic [DELAY_W-1:0]   dc_l,
    output logic                 dc_rst,
    input  logic                 dc_expired_pulse,
    output logic                 om_update,
    output logic [SHUTTER_W-1:0] om_shutter,
    output logic [SHUTTER_W-1:0] om_end_shutter,
    output logic                 om_pulse_mode,
    output logic                 om_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun,
    output logic [CNT_W-1:0]     segment_count
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [SHUTTER_W-1:0] shutter;
        logic [SHUTTER_W-1:0] end_shutter;
        logic [DELAY_W-1:0]   delay;
        logic                 pulse_mode;
        logic                 last;
    } seg_t;

    // ADVANCE is the one-cycle decision slot after a LOAD whose delay is too
    // short for the counter to produce an expiry.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } state_t;

    // ------------------------------------------------------------------
    // Segment buffer
    // ------------------------------------------------------------------
    seg_t                mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_BITS-1:0] fifo_count;
    logic [CNT_BITS-1:0] fifo_count_next;
    logic                push;
    logic                pop;
    logic                fifo_nonempty;
    seg_t                head;

    assign push          = cmd_valid && cmd_ready;
    assign fifo_nonempty = (fifo_count != '0);
    assign head          = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count need a
    // defined value, and leaving the data unreset keeps it in plain RAM cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{shutter:     cmd_shutter,
                             end_shutter: cmd_end_shutter,
                             delay:       cmd_delay,
                             pulse_mode:  cmd_pulse_mode,
                             last:        cmd_last};
        end
    end

    // Abort discards everything, including a push offered in the same cycle.
    always_comb begin
        fifo_count_next = fifo_count;
        if (abort) begin
            fifo_count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_count_next = fifo_count + 1'b1;
                2'b01:   fifo_count_next = fifo_count - 1'b1;
                default: fifo_count_next = fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_ready  <= 1'b0;
        end else begin
            fifo_count <= fifo_count_next;
            // Registered !full, derived from the count it will hold next cycle.
            cmd_ready  <= (fifo_count_next != CNT_BITS'(DEPTH));
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer control
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   last_r;
    logic   advance;
    logic   take_head;
    logic   set_underrun;
    logic   clear_run;
    logic   empty_start;

    assign pop = take_head;

    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers latches.
    always_comb begin
        state_next   = state;
        advance      = 1'b0;
        take_head    = 1'b0;
        set_underrun = 1'b0;
        clear_run    = 1'b0;
        empty_start  = 1'b0;

        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (fifo_nonempty) begin
                            take_head  = 1'b1;
                            clear_run  = 1'b1;
                            state_next = S_LOAD;
                        end else begin
                            set_underrun = 1'b1;
                            empty_start  = 1'b1;
                        end
                    end
                end
                // om_enable already holds (delay > 1) for the loaded segment.
                S_LOAD:    state_next = om_enable ? S_WAIT : S_ADVANCE;
                S_WAIT:    advance    = dc_expired_pulse;
                S_ADVANCE: advance    = 1'b1;
                S_FINISH:  state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase

            if (advance) begin
                if (last_r) begin
                    state_next = S_FINISH;
                end else if (fifo_nonempty) begin
                    take_head  = 1'b1;
                    state_next = S_LOAD;
                end else begin
                    set_underrun = 1'b1;
                    state_next   = S_FINISH;
                end
            end
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            last_r         <= 1'b0;
            dc_load        <= 1'b0;
            dc_l           <= '0;
            dc_rst         <= 1'b0;
            om_update      <= 1'b0;
            om_shutter     <= '0;
            om_end_shutter <= '0;
            om_pulse_mode  <= 1'b0;
            om_enable      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            underrun       <= 1'b0;
            segment_count  <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != S_IDLE);
            dc_load   <= take_head;
            om_update <= take_head;
            dc_rst    <= abort;
            done      <= empty_start || (state_next == S_FINISH);

            if (clear_run)         underrun <= 1'b0;
            else if (set_underrun) underrun <= 1'b1;

            // Output words change only on a load, so the multiplexer keeps
            // its last state through FINISH, IDLE and abort.
            if (take_head) begin
                dc_l           <= head.delay;
                om_shutter     <= head.shutter;
                om_end_shutter <= head.end_shutter;
                om_pulse_mode  <= head.pulse_mode;
                om_enable      <= (head.delay > DELAY_W'(1));
                last_r         <= head.last;
                segment_count  <= clear_run ? CNT_W'(1) : segment_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_segment_sequencer.sv
module tb_pulse_segment_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_shutter = '0;
    logic [63:0] cmd_end_shutter = '0;
    logic [47:0] cmd_delay = '0;
    logic        cmd_pulse_mode = 1'b0;
    logic        cmd_last = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dc_load;
    logic [47:0] dc_l;
    logic        dc_rst;
    logic        dc_expired_pulse = 1'b0;
    logic        om_update;
    logic [63:0] om_shutter;
    logic [63:0] om_end_shutter;
    logic        om_pulse_mode;
    logic        om_enable;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [15:0] segment_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Segment program used by run_seq.
    logic [63:0] seg_sh [8];
    logic [63:0] seg_es [8];
    int          seg_d  [8];
    bit          seg_pm [8];
    bit          seg_last [8];

    logic [200:0] all_out;
    assign all_out = {cmd_ready, dc_load, dc_rst, om_update, om_pulse_mode, om_enable,
                      busy, done, underrun, dc_l, om_shutter, om_end_shutter, segment_count};

    pulse_segment_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_shutter      (cmd_shutter),
        .cmd_end_shutter  (cmd_end_shutter),
        .cmd_delay        (cmd_delay),
        .cmd_pulse_mode   (cmd_pulse_mode),
        .cmd_last         (cmd_last),
        .start            (start),
        .abort            (abort),
        .dc_load          (dc_load),
        .dc_l             (dc_l),
        .dc_rst           (dc_rst),
        .dc_expired_pulse (dc_expired_pulse),
        .om_update        (om_update),
        .om_shutter       (om_shutter),
        .om_end_shutter   (om_end_shutter),
        .om_pulse_mode    (om_pulse_mode),
        .om_enable        (om_enable),
        .busy             (busy),
        .done             (done),
        .underrun         (underrun),
        .segment_count    (segment_count)
    );

    always #5 clk = ~clk;

    task automatic set_seg(input int i, input logic [63:0] sh, input logic [63:0] es,
                           input int d, input bit pm, input bit last);
        seg_sh[i]   = sh;
        seg_es[i]   = es;
        seg_d[i]    = d;
        seg_pm[i]   = pm;
        seg_last[i] = last;
    endtask

    task automatic drive_seg(input int i);
        cmd_shutter     = seg_sh[i];
        cmd_end_shutter = seg_es[i];
        cmd_delay       = 48'(seg_d[i]);
        cmd_pulse_mode  = seg_pm[i];
        cmd_last        = seg_last[i];
    endtask

    // Pushes seg[0..n-1] as fast as cmd_ready allows, starts once two (or n)
    // are queued, plays the counter by pulsing expiry delay-1 cycles after
    // each observed load, and checks the load/done timeline against one
    // computed from the segment delays: next event = load + max(delay, 2).
    task automatic run_seq(input string name, input int n);
        int idx, cyc, exp_at, nload, exp_next, done_cyc, exp_loads, step;
        bit acc, started, fin, exp_under;
        exp_loads = n;
        exp_under = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (seg_last[i] && exp_under) begin
                exp_loads = i + 1;
                exp_under = 1'b0;
            end
        end
        idx = 0; cyc = 0; exp_at = -1; nload = 0; exp_next = -1; done_cyc = -1;
        started = 1'b0; fin = 1'b0;
        while (!fin && cyc < 2000) begin
            if (idx < n) begin
                cmd_valid = 1'b1;
                drive_seg(idx);
                acc = cmd_ready;
            end else begin
                cmd_valid = 1'b0;
                acc = 1'b0;
            end
            start = 1'b0;
            if (!started && idx >= ((n < 2) ? n : 2)) begin
                start    = 1'b1;
                started  = 1'b1;
                exp_next = cyc + 1;
                if (n >= 2) begin
                    tests_run++;
                    if (cmd_ready !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL %s ready_full: cmd_ready=%b want 0 with 2 held", name, cmd_ready);
                    end
                end
            end
            dc_expired_pulse = (cyc == exp_at);
            @(negedge clk);
            cyc++;
            if (cmd_valid && acc) idx++;
            if (dc_load === 1'b1) begin
                tests_run++;
                if (nload >= exp_loads || cyc != exp_next) begin
                    tests_failed++;
                    $display("FAIL %s load_timing: load #%0d at cycle %0d want cycle %0d (of %0d loads)",
                             name, nload, cyc, exp_next, exp_loads);
                end else begin
                    tests_run++;
                    if ({dc_l, om_shutter, om_end_shutter, om_pulse_mode, om_enable, om_update} !==
                        {48'(seg_d[nload]), seg_sh[nload], seg_es[nload], seg_pm[nload],
                         (seg_d[nload] > 1), 1'b1}) begin
                        tests_failed++;
                        $display("FAIL %s load_fields #%0d: dc_l=%0d sh=%h es=%h pm=%b en=%b upd=%b want dc_l=%0d sh=%h es=%h pm=%b en=%b upd=1",
                                 name, nload, dc_l, om_shutter, om_end_shutter, om_pulse_mode, om_enable,
                                 om_update, seg_d[nload], seg_sh[nload], seg_es[nload], seg_pm[nload],
                                 (seg_d[nload] > 1));
                    end
                    step     = (seg_d[nload] > 1) ? seg_d[nload] : 2;
                    exp_at   = (seg_d[nload] > 1) ? cyc + seg_d[nload] - 1 : -1;
                    exp_next = cyc + step;
                end
                nload++;
            end
            if (done === 1'b1) begin
                fin      = 1'b1;
                done_cyc = cyc;
            end
        end
        cmd_valid = 1'b0;
        start = 1'b0;
        dc_expired_pulse = 1'b0;
        tests_run++;
        if (!fin) begin
            tests_failed++;
            $display("FAIL %s timeout: no done within %0d cycles (loads seen %0d)", name, cyc, nload);
        end else begin
            tests_run++;
            if (nload != exp_loads) begin
                tests_failed++;
                $display("FAIL %s load_count: got %0d want %0d", name, nload, exp_loads);
            end
            tests_run++;
            if (done_cyc != exp_next) begin
                tests_failed++;
                $display("FAIL %s done_timing: done at %0d want %0d", name, done_cyc, exp_next);
            end
            tests_run++;
            if ({underrun, segment_count, busy} !== {exp_under, 16'(exp_loads), 1'b1}) begin
                tests_failed++;
                $display("FAIL %s end_status: underrun=%b count=%0d busy=%b want underrun=%b count=%0d busy=1",
                         name, underrun, segment_count, busy, exp_under, exp_loads);
            end
            @(negedge clk);
            tests_run++;
            if ({done, busy, cmd_ready} !== 3'b001) begin
                tests_failed++;
                $display("FAIL %s after_done: done=%b busy=%b ready=%b want 0 0 1", name, done, busy, cmd_ready);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: outputs=%h want 0", all_out);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (all_out !== {1'b1, 200'b0}) begin
            tests_failed++;
            $display("FAIL reset_release: outputs=%h want only cmd_ready set", all_out);
        end
    endtask

    task automatic test_single();
        set_seg(0, 64'h0123456789abcdef, 64'hfedcba9876543210, 10, 1'b1, 1'b1);
        run_seq("single", 1);
    endtask

    task automatic test_three();
        set_seg(0, 64'h1111_0000_aaaa_0001, 64'h0000_1111_5555_0001, 10, 1'b1, 1'b0);
        set_seg(1, 64'h2222_0000_aaaa_0002, 64'h0000_2222_5555_0002, 50, 1'b0, 1'b0);
        set_seg(2, 64'h3333_0000_aaaa_0003, 64'h0000_3333_5555_0003, 20, 1'b1, 1'b1);
        run_seq("three", 3);
    endtask

    task automatic test_underrun();
        set_seg(0, 64'hdead_beef_0000_0001, 64'h0, 7, 1'b1, 1'b0);
        set_seg(1, 64'hdead_beef_0000_0002, 64'h1, 4, 1'b0, 1'b0);
        run_seq("underrun", 2);
    endtask

    task automatic test_delay1();
        set_seg(0, 64'h0f0f_0f0f_0f0f_0f0f, 64'h0101, 1, 1'b1, 1'b0);
        set_seg(1, 64'hf0f0_f0f0_f0f0_f0f0, 64'h0202, 5, 1'b1, 1'b1);
        run_seq("delay1", 2);
    endtask

    task automatic test_random();
        int n;
        bit with_last;
        for (int t = 0; t < 12; t++) begin
            n = 1 + $urandom_range(0, 4);
            with_last = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) begin
                set_seg(i, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 12),
                        1'($urandom_range(0, 1)), with_last && (i == n - 1));
            end
            run_seq($sformatf("random%0d", t), n);
        end
    endtask

    task automatic test_abort();
        set_seg(0, 64'habcd_0000_1234_5678, 64'h5555_aaaa_5555_aaaa, 50, 1'b1, 1'b1);
        set_seg(1, 64'h9999_9999_9999_9999, 64'h7777, 8, 1'b0, 1'b1);
        cmd_valid = 1'b1;
        drive_seg(0);
        @(negedge clk);
        cmd_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({dc_load, dc_l, segment_count} !== {1'b1, 48'd50, 16'd1}) begin
            tests_failed++;
            $display("FAIL abort_load: dc_load=%b dc_l=%0d count=%0d want 1 50 1", dc_load, dc_l, segment_count);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if ({cmd_ready, dc_rst, busy} !== 3'b101) begin
            tests_failed++;
            $display("FAIL abort_wait: ready=%b dc_rst=%b busy=%b want 1 0 1", cmd_ready, dc_rst, busy);
        end
        // abort, expiry and a push all land in the same cycle.
        abort = 1'b1;
        dc_expired_pulse = 1'b1;
        cmd_valid = 1'b1;
        drive_seg(1);
        @(negedge clk);
        abort = 1'b0;
        dc_expired_pulse = 1'b0;
        cmd_valid = 1'b0;
        tests_run++;
        if ({dc_rst, done, busy, dc_load} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL abort_cycle: dc_rst=%b done=%b busy=%b dc_load=%b want 1 0 0 0", dc_rst, done, busy, dc_load);
        end
        @(negedge clk);
        tests_run++;
        if ({dc_rst, done, cmd_ready, om_shutter, om_end_shutter, segment_count} !==
            {1'b0, 1'b0, 1'b1, seg_sh[0], seg_es[0], 16'd1}) begin
            tests_failed++;
            $display("FAIL abort_after: dc_rst=%b done=%b ready=%b sh=%h es=%h count=%0d want 0 0 1 %h %h 1",
                     dc_rst, done, cmd_ready, om_shutter, om_end_shutter, segment_count, seg_sh[0], seg_es[0]);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({done, underrun, dc_load, busy} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL abort_empty_start: done=%b underrun=%b dc_load=%b busy=%b want 1 1 0 0",
                     done, underrun, dc_load, busy);
        end
        @(negedge clk);
        tests_run++;
        if ({done, underrun} !== 2'b01) begin
            tests_failed++;
            $display("FAIL abort_sticky: done=%b underrun=%b want 0 1", done, underrun);
        end
    endtask

    task automatic test_rst_mid();
        set_seg(0, 64'h0bad_cafe_0bad_cafe, 64'h1234, 50, 1'b1, 1'b1);
        cmd_valid = 1'b1;
        drive_seg(0);
        @(negedge clk);
        cmd_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_busy: busy=%b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: outputs=%h want 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (all_out !== {1'b1, 200'b0}) begin
            tests_failed++;
            $display("FAIL rst_mid_release: outputs=%h want only cmd_ready set", all_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_underrun();
        test_delay1();
        test_random();
        test_abort();
        test_rst_mid();
        test_three();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
